pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage ARM pipeline. Merges the hazard unit's `hazard_detected`, the EXE-stage branch-taken signal and the MEM-stage SRAM handshake into one set of per-stage freeze/flush controls. It also tracks multi-cycle memory waits with a timeout and keeps saturating performance counters. It sits beside the hazard unit and drives the enables/clears of the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_stall_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear drops the same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      q <= '0;
    else if (inc && (q != {W{1'b1}}))
      q <= q + W'(1);
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: merges hazard, branch and SRAM handshake into per-stage
// freeze/flush controls, with a MEM wait timeout and saturating statistics.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_stats,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    freeze_all = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          freeze_all = 1'b1;
          state_nxt  = ST_MEM_WAIT;
          wait_nxt   = WC_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        freeze_all = !mem_ready;
        // ready in the same cycle the count hits TIMEOUT still releases
        if (mem_ready) begin
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WC_W'(TIMEOUT)) begin
          state_nxt = ST_ERROR;
        end else begin
          wait_nxt = wait_cnt + WC_W'(1);
        end
      end
      default: begin
        freeze_all = 1'b1;
        state_nxt  = ST_ERROR;
      end
    endcase
  end

  // Branch squashes the hazarding instruction, so it wins over the hazard stall.
  always_comb begin
    freeze_if = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    if (freeze_all) begin
      freeze_if = 1'b1;
    end else if (branch_taken) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (hazard_detected) begin
      freeze_if = 1'b1;
      flush_id  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  assign mem_timeout = (state == ST_ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_stats),
    .inc (freeze_if | freeze_all),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_stats),
    .inc (flush_if),
    .q   (flush_events)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: per-cycle expectations queued at drive time from a
// reference model, compared at the falling edge, plus directed counter/timeout checks.
module tb_pipeline_stall_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 3;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, hazard_detected, branch_taken, mem_req, mem_ready, clr_stats;
  logic          freeze_if, flush_if, flush_id, freeze_all, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  pipeline_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .clr_stats       (clr_stats),
    .freeze_if       (freeze_if),
    .flush_if        (flush_if),
    .flush_id        (flush_id),
    .freeze_all      (freeze_all),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fi, fli, fld, fa, mt;
    int   sc, fe;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // model state: 0 RUN, 1 MEM_WAIT, 2 ERROR
  int m_st, m_w, m_sc, m_fe;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_w = 0; m_sc = 0; m_fe = 0;
  endtask

  // One clock: drive, queue expectation, compare at negedge, advance model at posedge.
  task automatic cyc(input logic h, input logic b, input logic req, input logic rdy,
                     input logic clr, input logic rs);
    exp_t e, o;
    rst = rs; hazard_detected = h; branch_taken = b;
    mem_req = req; mem_ready = rdy; clr_stats = clr;
    e.fa = (m_st == 2) || (m_st == 1 && !rdy) || (m_st == 0 && req && !rdy);
    e.fi = 1'b0; e.fli = 1'b0; e.fld = 1'b0;
    if (e.fa)     e.fi = 1'b1;
    else if (b)   begin e.fli = 1'b1; e.fld = 1'b1; end
    else if (h)   begin e.fi = 1'b1; e.fld = 1'b1; end
    e.mt = (m_st == 2);
    e.sc = m_sc;
    e.fe = m_fe;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    chk("freeze_if",    int'(freeze_if),    int'(o.fi));
    chk("flush_if",     int'(flush_if),     int'(o.fli));
    chk("flush_id",     int'(flush_id),     int'(o.fld));
    chk("freeze_all",   int'(freeze_all),   int'(o.fa));
    chk("mem_timeout",  int'(mem_timeout),  int'(o.mt));
    chk("stall_cycles", int'(stall_cycles), o.sc);
    chk("flush_events", int'(flush_events), o.fe);
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      if (clr) begin
        m_sc = 0; m_fe = 0;
      end else begin
        if ((e.fi || e.fa) && m_sc < MAXC) m_sc++;
        if (e.fli && m_fe < MAXC) m_fe++;
      end
      case (m_st)
        0: if (req && !rdy) begin m_st = 1; m_w = 1; end
        1: if (rdy) begin m_st = 0; m_w = 0; end
           else if (m_w == TO) m_st = 2;
           else m_w++;
        default: m_st = 2;
      endcase
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clr_cyc();
    cyc(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    rst = 1'b1; hazard_detected = 0; branch_taken = 0;
    mem_req = 0; mem_ready = 0; clr_stats = 0;
    @(posedge clk); #1;
    model_reset();
    cyc(1, 1, 1, 0, 0, 1);          // reset with busy inputs
    idle();                          // reset state: all zero

    // hazard only for 2 cycles
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("hz_stall", int'(stall_cycles), 2);
    idle(); clr_cyc();
    chk("clr_zero", int'(stall_cycles), 0);

    // branch beats hazard
    cyc(1, 1, 0, 0, 0, 0);
    chk("br_flush", int'(flush_events), 1);
    chk("br_nostall", int'(stall_cycles), 0);
    clr_cyc();

    // 3-cycle SRAM wait, ready on the 4th
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("wait3_stall", int'(stall_cycles), 3);
    idle(); clr_cyc();

    // branch held through a 2-cycle wait, flushed on release
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    chk("brw_flush", int'(flush_events), 1);
    chk("brw_stall", int'(stall_cycles), 2);
    clr_cyc();

    // zero-wait access, then ready exactly at the TIMEOUT count
    cyc(1, 0, 1, 1, 0, 0);
    repeat (TO) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("edge_no_to", int'(mem_timeout), 0);
    idle(); clr_cyc();

    // timeout: cycles 0..TO wait, mem_timeout from TO+1
    repeat (TO + 1) cyc(0, 0, 1, 0, 0, 0);
    chk("to_set", int'(mem_timeout), 1);
    cyc(1, 1, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("to_sticky", int'(mem_timeout), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("to_rst", int'(mem_timeout), 0);
    chk("to_rst_cnt", int'(stall_cycles), 0);
    idle();

    // saturation then clear
    repeat (10) cyc(1, 0, 0, 0, 0, 0);
    chk("sat", int'(stall_cycles), MAXC);
    clr_cyc();
    chk("sat_clr", int'(stall_cycles), 0);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
